// File: rtl/rf_scoreboard.sv
// Register-busy scoreboard: stalls issue on RAW/WAW hazards, tracks in-flight rf writes.
// Optional macro RF_SCOREBOARD_WB_BYPASS_EN treats a register being written back this cycle as free.
module rf_scoreboard #(
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [4:0]       issue_rs1_addr,
  input  logic             issue_rs1_used,
  input  logic [4:0]       issue_rs2_addr,
  input  logic             issue_rs2_used,
  input  logic [4:0]       issue_rd_addr,
  input  logic             issue_rd_we,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd_addr,
  input  logic             flush,
  output logic [31:0]      busy_vec,
  output logic [CNT_W-1:0] inflight_cnt,
  output logic             wb_err
);

  logic [31:0]      busy_q, busy_d, busy_eff, wb_mask;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_eff;
  logic             wb_err_q, wb_err_d;
  logic             wb_hit, wb_frees, rd_nz, raw1, raw2, waw, full, set_rd;

  always_comb begin
    wb_hit   = wb_valid & ~flush & (wb_rd_addr != 5'd0);
    wb_frees = wb_hit & busy_q[wb_rd_addr];
    wb_mask  = 32'd1 << wb_rd_addr;
`ifdef RF_SCOREBOARD_WB_BYPASS_EN
    // Relies on the rf write-through forward path to supply the value being written.
    busy_eff = wb_hit ? (busy_q & ~wb_mask) : busy_q;
    cnt_eff  = cnt_q - CNT_W'(wb_frees);
`else
    busy_eff = busy_q;
    cnt_eff  = cnt_q;
`endif
  end

  always_comb begin
    rd_nz       = issue_rd_addr != 5'd0;
    raw1        = issue_rs1_used & busy_eff[issue_rs1_addr];
    raw2        = issue_rs2_used & busy_eff[issue_rs2_addr];
    waw         = issue_rd_we & rd_nz & busy_eff[issue_rd_addr];
    full        = issue_rd_we & rd_nz & (cnt_eff == CNT_W'(MAX_INFLIGHT));
    issue_ready = ~flush & ~raw1 & ~raw2 & ~waw & ~full;
    set_rd      = issue_valid & issue_ready & issue_rd_we & rd_nz;
  end

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    wb_err_d = 1'b0;
    if (flush) begin
      busy_d = '0;
      cnt_d  = '0;
    end else begin
      wb_err_d = wb_hit & ~busy_q[wb_rd_addr];
      if (wb_frees) busy_d = busy_d & ~wb_mask;
      // Set after clear so a same-register set wins (bypass builds only).
      if (set_rd) busy_d[issue_rd_addr] = 1'b1;
      if (set_rd && !wb_frees)      cnt_d = cnt_q + CNT_W'(1);
      else if (!set_rd && wb_frees) cnt_d = cnt_q - CNT_W'(1);
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q   <= '0;
      cnt_q    <= '0;
      wb_err_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      wb_err_q <= wb_err_d;
    end
  end

  assign busy_vec     = busy_q;
  assign inflight_cnt = cnt_q;
  assign wb_err       = wb_err_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed self-checking bench for rf_scoreboard (MAX_INFLIGHT = 4).
module tb_rf_scoreboard;

  localparam int unsigned MaxInflight = 4;
  localparam int unsigned CntW        = $clog2(MaxInflight + 1);

  logic            clk = 1'b0;
  logic            reset;
  logic            issue_valid, issue_ready;
  logic [4:0]      issue_rs1_addr, issue_rs2_addr, issue_rd_addr, wb_rd_addr;
  logic            issue_rs1_used, issue_rs2_used, issue_rd_we;
  logic            wb_valid, flush, wb_err;
  logic [31:0]     busy_vec;
  logic [CntW-1:0] inflight_cnt;

  int checks = 0;
  int errors = 0;

  rf_scoreboard #(
    .MAX_INFLIGHT (MaxInflight)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_rs1_addr (issue_rs1_addr),
    .issue_rs1_used (issue_rs1_used),
    .issue_rs2_addr (issue_rs2_addr),
    .issue_rs2_used (issue_rs2_used),
    .issue_rd_addr  (issue_rd_addr),
    .issue_rd_we    (issue_rd_we),
    .wb_valid       (wb_valid),
    .wb_rd_addr     (wb_rd_addr),
    .flush          (flush),
    .busy_vec       (busy_vec),
    .inflight_cnt   (inflight_cnt),
    .wb_err         (wb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Count must always equal the popcount of busy bits, and x0 is never busy.
  always @(negedge clk) begin
    if (!reset) begin
      check("inv_popcnt", 32'(inflight_cnt), 32'($countones(busy_vec)));
      check("inv_x0", 32'(busy_vec[0]), 32'd0);
    end
  end

  task automatic idle();
    issue_valid = 0; issue_rs1_used = 0; issue_rs2_used = 0; issue_rd_we = 0;
    issue_rs1_addr = 0; issue_rs2_addr = 0; issue_rd_addr = 0;
    wb_valid = 0; wb_rd_addr = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_wr(input logic [4:0] rd);
    idle();
    issue_valid = 1; issue_rd_we = 1; issue_rd_addr = rd;
  endtask

  task automatic check_state(input string tag, input logic [31:0] busy, input int cnt,
                             input logic err);
    check({tag, "_busy"}, busy_vec, busy);
    check({tag, "_cnt"}, 32'(inflight_cnt), 32'(cnt));
    check({tag, "_err"}, 32'(wb_err), 32'(err));
  endtask

  initial begin
    idle();
    reset = 1;
    #2;
    check_state("reset_hold", 32'h0, 0, 1'b0);
    tick();
    reset = 0;

    // Scenario 1: issue write to x5, then a RAW on x5 stalls.
    issue_wr(5'd5);
    #1 check("s1_ready", 32'(issue_ready), 32'd1);
    tick();
    check_state("s1_set", 32'h20, 1, 1'b0);
    idle();
    issue_rs1_addr = 5; issue_rs1_used = 1;
    #1 check("s1_raw", 32'(issue_ready), 32'd0);

    // Scenario 2: writeback frees x5.
    wb_valid = 1; wb_rd_addr = 5;
`ifdef RF_SCOREBOARD_WB_BYPASS_EN
    #1 check("s2_wb_cycle", 32'(issue_ready), 32'd1);
`else
    #1 check("s2_wb_cycle", 32'(issue_ready), 32'd0);
`endif
    tick();
    wb_valid = 0;
    #1;
    check_state("s2_clr", 32'h0, 0, 1'b0);
    check("s2_ready", 32'(issue_ready), 32'd1);

    // Scenario 3: fill to MAX_INFLIGHT.
    for (int r = 1; r <= 4; r++) begin
      issue_wr(5'(r));
      tick();
    end
    idle();
    check_state("s3_full", 32'h1E, 4, 1'b0);
    issue_rd_we = 1; issue_rd_addr = 6;
    #1 check("s3_full_stall", 32'(issue_ready), 32'd0);
    issue_rd_addr = 0;
    #1 check("s3_rd_x0", 32'(issue_ready), 32'd1);
    issue_rd_we = 0; issue_rd_addr = 6; issue_rs1_used = 1; issue_rs1_addr = 7;
    #1 check("s3_no_we", 32'(issue_ready), 32'd1);
    issue_rs2_used = 1; issue_rs2_addr = 3;
    #1 check("s3_raw2", 32'(issue_ready), 32'd0);
    idle();
    issue_rd_we = 1; issue_rd_addr = 2;
    #1 check("s3_waw", 32'(issue_ready), 32'd0);

    // Scenario 4: spurious writebacks.
    idle();
    wb_valid = 1; wb_rd_addr = 9;
    tick();
    idle();
    check_state("s4_err", 32'h1E, 4, 1'b1);
    tick();
    check_state("s4_err_gone", 32'h1E, 4, 1'b0);
    wb_valid = 1; wb_rd_addr = 0;
    tick();
    idle();
    check_state("s4_x0", 32'h1E, 4, 1'b0);

    // Same-cycle accept and writeback to different registers.
    wb_valid = 1; wb_rd_addr = 4;
    tick();
    check_state("s4_free4", 32'h0E, 3, 1'b0);
    issue_wr(5'd7);
    wb_valid = 1; wb_rd_addr = 3;
    tick();
    check_state("s4_swap", 32'h86, 3, 1'b0);
    issue_wr(5'd3);
    wb_valid = 1; wb_rd_addr = 7;
    tick();
    check_state("s4_swap2", 32'h0E, 3, 1'b0);

    // Scenario 5: flush with coincident writeback.
    issue_wr(5'd10);
    flush = 1; wb_valid = 1; wb_rd_addr = 2;
    #1 check("s5_ready", 32'(issue_ready), 32'd0);
    tick();
    idle();
    check_state("s5_flushed", 32'h0, 0, 1'b0);
    wb_valid = 1; wb_rd_addr = 1;
    tick();
    idle();
    check_state("s5_late_wb", 32'h0, 0, 1'b1);
    tick();

    // Scenario 6: asynchronous reset mid-operation.
    for (int r = 1; r <= 4; r++) begin
      issue_wr(5'(r));
      tick();
    end
    idle();
    check_state("s6_pre", 32'h1E, 4, 1'b0);
    #2 reset = 1;
    #1 check_state("s6_async", 32'h0, 0, 1'b0);
    tick();
    #2 reset = 0;
    tick();
    issue_wr(5'd5);
    #1 check("s6_ready", 32'(issue_ready), 32'd1);
    tick();
    idle();
    check_state("s6_set", 32'h20, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
